// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM command path.
// Used by the test sequencer and the PWM generator.
package pwm_pkg;

  localparam int CLK_HZ          = 12_000_000;
  localparam int FRAME_CYCLES    = 240_000;
  localparam int DEBOUNCE_CYCLES = 240_000;
  localparam int MIN_PULSE       = 12_000;
  localparam int MAX_PULSE       = 24_000;
  localparam int STEP            = 120;
  localparam int ARM_FRAMES      = 100;
  localparam int HOLD_FRAMES     = 250;
  localparam int DUTY_W          = 18;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RAMP_DOWN = 3'd4
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Button synchroniser, stability counter and rising-edge pulse.
// A new level is accepted after DEBOUNCE_CYCLES identical samples.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 240_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] L_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = r_s2 ^ r_level;
  assign w_accept = w_diff && (r_cnt == L_LAST);
  assign o_rise   = r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= w_accept && r_s2;
      if (w_accept) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_test_sequencer.sv
// Frame-synchronous arm / ramp / hold / ramp-down power test profile.
// Duty words change only one clock after a frame tick, or on abort.
module pwm_test_sequencer #(
  parameter int FRAME_CYCLES    = pwm_pkg::FRAME_CYCLES,
  parameter int DEBOUNCE_CYCLES = pwm_pkg::DEBOUNCE_CYCLES,
  parameter int MIN_PULSE       = pwm_pkg::MIN_PULSE,
  parameter int MAX_PULSE       = pwm_pkg::MAX_PULSE,
  parameter int STEP            = pwm_pkg::STEP,
  parameter int ARM_FRAMES      = pwm_pkg::ARM_FRAMES,
  parameter int HOLD_FRAMES     = pwm_pkg::HOLD_FRAMES,
  parameter int DUTY_W          = pwm_pkg::DUTY_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [DUTY_W-1:0] o_duty_esc,
  output logic [DUTY_W-1:0] o_duty_servo1,
  output logic [DUTY_W-1:0] o_duty_servo2,
  output logic              o_duty_update,
  output logic              o_frame_tick,
  output logic              o_busy,
  output logic [2:0]        o_state
);

  import pwm_pkg::*;

  localparam int FCW = $clog2(FRAME_CYCLES);
  localparam int NW  = 16;
  localparam int WW  = DUTY_W + 1;

  localparam logic [FCW-1:0] L_FRAME_LAST = FCW'(FRAME_CYCLES - 1);
  localparam logic [NW-1:0]  L_ARM_LAST   = NW'(ARM_FRAMES - 1);
  localparam logic [NW-1:0]  L_HOLD_LAST  = NW'(HOLD_FRAMES - 1);
  localparam logic [WW-1:0]  L_STEP_W     = WW'(STEP);
  localparam logic [WW-1:0]  L_MAX_W      = WW'(MAX_PULSE);
  localparam logic [WW-1:0]  L_DN_LIM     = WW'(MIN_PULSE + STEP);
  localparam logic [DUTY_W-1:0] L_STEP    = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] L_MIN     = DUTY_W'(MIN_PULSE);
  localparam logic [DUTY_W-1:0] L_MAX     = DUTY_W'(MAX_PULSE);
  localparam logic [DUTY_W-1:0] L_SUM     = DUTY_W'(MIN_PULSE + MAX_PULSE);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [FCW-1:0]    r_fcnt;
  logic [NW-1:0]     r_frames;
  logic [NW-1:0]     w_frames_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic [DUTY_W-1:0] r_esc;
  logic [DUTY_W-1:0] w_esc_nxt;
  logic [DUTY_W-1:0] r_servo1;
  logic [DUTY_W-1:0] r_servo2;
  logic              r_upd;
  logic              w_tick;
  logic              w_busy;
  logic              w_start;
  logic [WW-1:0]     w_up;
  logic [DUTY_W-1:0] w_dn;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_start),
    .o_rise (w_start)
  );

  assign w_tick = (r_fcnt == L_FRAME_LAST);
  assign w_busy = (r_state != ST_IDLE);
  assign w_up   = {1'b0, r_esc} + L_STEP_W;
  assign w_dn   = r_esc - L_STEP;

  always_comb begin
    w_state_nxt   = r_state;
    w_frames_nxt  = r_frames;
    w_pending_nxt = r_pending;
    w_esc_nxt     = r_esc;
    if (w_start && !w_busy && !i_abort) begin
      w_pending_nxt = 1'b1;
    end
    if (i_abort) begin
      w_pending_nxt = 1'b0;
      if (w_busy) begin
        w_state_nxt = ST_IDLE;
        w_esc_nxt   = L_MIN;
      end
    end else if (w_tick) begin
      unique case (r_state)
        ST_ARM: begin
          w_esc_nxt = L_MIN;
          if (r_frames == L_ARM_LAST) w_state_nxt = ST_RAMP_UP;
          else w_frames_nxt = r_frames + 1'b1;
        end
        ST_RAMP_UP: begin
          if (w_up >= L_MAX_W) begin
            w_esc_nxt    = L_MAX;
            w_state_nxt  = ST_HOLD;
            w_frames_nxt = '0;
          end else begin
            w_esc_nxt = w_up[DUTY_W-1:0];
          end
        end
        ST_HOLD: begin
          w_esc_nxt = L_MAX;
          if (r_frames == L_HOLD_LAST) w_state_nxt = ST_RAMP_DOWN;
          else w_frames_nxt = r_frames + 1'b1;
        end
        ST_RAMP_DOWN: begin
          // compare before subtracting so the clamp never sees a wrap
          if ({1'b0, r_esc} <= L_DN_LIM) begin
            w_esc_nxt   = L_MIN;
            w_state_nxt = ST_IDLE;
          end else begin
            w_esc_nxt = w_dn;
          end
        end
        default: begin
          if (r_pending) begin
            w_state_nxt   = ST_ARM;
            w_pending_nxt = 1'b0;
            w_frames_nxt  = '0;
            w_esc_nxt     = L_MIN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_fcnt    <= '0;
      r_frames  <= '0;
      r_pending <= 1'b0;
      r_esc     <= L_MIN;
      r_servo1  <= L_MIN;
      r_servo2  <= L_MAX;
      r_upd     <= 1'b0;
    end else begin
      r_fcnt    <= w_tick ? '0 : r_fcnt + 1'b1;
      r_state   <= w_state_nxt;
      r_frames  <= w_frames_nxt;
      r_pending <= w_pending_nxt;
      r_esc     <= w_esc_nxt;
      r_servo1  <= w_esc_nxt;
      r_servo2  <= L_SUM - w_esc_nxt;
      r_upd     <= (w_esc_nxt != r_esc);
    end
  end

  assign o_duty_esc    = r_esc;
  assign o_duty_servo1 = r_servo1;
  assign o_duty_servo2 = r_servo2;
  assign o_duty_update = r_upd;
  assign o_frame_tick  = w_tick;
  assign o_busy        = w_busy;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pwm_test_sequencer.sv
// Directed bench for the PWM test sequencer with shortened timing.
// Each scenario task drives stimulus and checks its own results.
module tb_pwm_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [17:0] esc;
  logic [17:0] s1;
  logic [17:0] s2;
  logic        upd;
  logic        tick;
  logic        busy;
  logic [2:0]  st;

  int pass_cnt = 0;
  int total = 0;

  logic [2:0]  st_log [16];
  logic [17:0] esc_log [12];
  logic [17:0] s1_log [12];
  logic [17:0] s2_log [12];
  int n_st;
  int n_upd;

  logic [2:0] exp_st [14] =
    '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3,
      3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
  int exp_esc [8] =
    '{15000, 18000, 21000, 24000,
      21000, 18000, 15000, 12000};

  always #5 clk = ~clk;

  pwm_test_sequencer #(
    .FRAME_CYCLES(100),
    .DEBOUNCE_CYCLES(8),
    .STEP(3000),
    .ARM_FRAMES(2),
    .HOLD_FRAMES(3)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .o_duty_esc   (esc),
    .o_duty_servo1(s1),
    .o_duty_servo2(s2),
    .o_duty_update(upd),
    .o_frame_tick (tick),
    .o_busy       (busy),
    .o_state      (st)
  );

  task automatic wait_tick();
    int k = 0;
    @(negedge clk);
    while (tick !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 200) $display("FAIL tick_wait timeout after %0d clocks", k);
    else pass_cnt++;
  endtask

  task automatic run_profile(input bit start_press, input bit hold_press);
    int press = start_press ? 20 : 0;
    bit injected = 1'b0;
    bit prev = 1'b0;
    int cyc = 0;
    n_st = 0;
    n_upd = 0;
    for (int i = 0; i < 16; i++) st_log[i] = 3'd7;
    for (int i = 0; i < 12; i++) begin
      esc_log[i] = '0;
      s1_log[i] = '0;
      s2_log[i] = '0;
    end
    while (n_st < 14 && cyc < 2000) begin
      if (hold_press && !injected && n_st == 7) begin
        press = 20;
        injected = 1'b1;
      end
      start = (press > 0);
      if (press > 0) press--;
      @(negedge clk);
      cyc++;
      if (prev) begin
        st_log[n_st] = st;
        n_st++;
      end
      prev = tick;
      if (upd) begin
        if (n_upd < 12) begin
          esc_log[n_upd] = esc;
          s1_log[n_upd] = s1;
          s2_log[n_upd] = s2;
        end
        n_upd++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    int nupd = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 7;
    if (esc !== 18'd12000) $display("FAIL rst_esc got %0d want 12000", esc);
    else pass_cnt++;
    if (s1 !== 18'd12000) $display("FAIL rst_s1 got %0d want 12000", s1);
    else pass_cnt++;
    if (s2 !== 18'd24000) $display("FAIL rst_s2 got %0d want 24000", s2);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    if (upd !== 1'b0) $display("FAIL rst_upd got %b want 0", upd);
    else pass_cnt++;
    if (tick !== 1'b0) $display("FAIL rst_tick got %b want 0", tick);
    else pass_cnt++;
    if (st !== 3'd0) $display("FAIL rst_state got %0d want 0", st);
    else pass_cnt++;
    rst_n = 1'b1;
    k = 0;
    while (tick !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (upd) nupd++;
    end
    total++;
    if (k !== 99) $display("FAIL first_tick got %0d want 99", k);
    else pass_cnt++;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (upd) nupd++;
    end while (tick !== 1'b1 && k < 300);
    total += 3;
    if (k !== 100) $display("FAIL tick_period got %0d want 100", k);
    else pass_cnt++;
    if (nupd !== 0) $display("FAIL idle_updates got %0d want 0", nupd);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_clean_start();
    wait_tick();
    @(negedge clk);
    run_profile(1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      total++;
      if (st_log[i] !== exp_st[i])
        $display("FAIL prof_state[%0d] got %0d want %0d",
                 i, st_log[i], exp_st[i]);
      else pass_cnt++;
    end
    total++;
    if (n_upd !== 8) $display("FAIL prof_updates got %0d want 8", n_upd);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total += 3;
      if (esc_log[i] !== exp_esc[i])
        $display("FAIL prof_esc[%0d] got %0d want %0d",
                 i, esc_log[i], exp_esc[i]);
      else pass_cnt++;
      if (s1_log[i] !== exp_esc[i])
        $display("FAIL prof_s1[%0d] got %0d want %0d",
                 i, s1_log[i], exp_esc[i]);
      else pass_cnt++;
      if (s2_log[i] !== 36000 - exp_esc[i])
        $display("FAIL prof_s2[%0d] got %0d want %0d",
                 i, s2_log[i], 36000 - exp_esc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    int nbusy = 0;
    int nupd = 0;
    for (int i = 0; i < 60; i++) begin
      start = ((i / 5) % 2 == 0);
      @(negedge clk);
      if (busy) nbusy++;
    end
    start = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (upd) nupd++;
    end
    total += 3;
    if (nbusy !== 0) $display("FAIL bounce_busy got %0d want 0", nbusy);
    else pass_cnt++;
    if (nupd !== 0) $display("FAIL bounce_upd got %0d want 0", nupd);
    else pass_cnt++;
    if (st !== 3'd0) $display("FAIL bounce_state got %0d want 0", st);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int k = 0;
    int nupd = 0;
    int nbusy = 0;
    wait_tick();
    @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    while (esc !== 18'd18000 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    total += 2;
    if (k >= 1000) $display("FAIL abort_reach got esc %0d want 18000", esc);
    else pass_cnt++;
    if (st !== 3'd2) $display("FAIL abort_pre_state got %0d want 2", st);
    else pass_cnt++;
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total += 6;
    if (esc !== 18'd12000) $display("FAIL abort_esc got %0d want 12000", esc);
    else pass_cnt++;
    if (s1 !== 18'd12000) $display("FAIL abort_s1 got %0d want 12000", s1);
    else pass_cnt++;
    if (s2 !== 18'd24000) $display("FAIL abort_s2 got %0d want 24000", s2);
    else pass_cnt++;
    if (st !== 3'd0) $display("FAIL abort_state got %0d want 0", st);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
    else pass_cnt++;
    if (upd !== 1'b1) $display("FAIL abort_upd got %b want 1", upd);
    else pass_cnt++;
    repeat (300) begin
      @(negedge clk);
      if (upd) nupd++;
      if (busy) nbusy++;
    end
    total += 2;
    if (nupd !== 0) $display("FAIL abort_after_upd got %0d want 0", nupd);
    else pass_cnt++;
    if (nbusy !== 0) $display("FAIL abort_after_busy got %0d want 0", nbusy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nbusy = 0;
    wait_tick();
    @(negedge clk);
    run_profile(1'b1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      total++;
      if (st_log[i] !== exp_st[i])
        $display("FAIL b2b_state[%0d] got %0d want %0d",
                 i, st_log[i], exp_st[i]);
      else pass_cnt++;
    end
    total += 2;
    if (n_upd !== 8) $display("FAIL b2b_updates got %0d want 8", n_upd);
    else pass_cnt++;
    if (esc_log[3] !== 18'd24000)
      $display("FAIL b2b_peak got %0d want 24000", esc_log[3]);
    else pass_cnt++;
    repeat (300) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    total++;
    if (nbusy !== 0) $display("FAIL b2b_restart got %0d want 0", nbusy);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int k = 0;
    int nbusy = 0;
    wait_tick();
    @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    while (st !== 3'd3 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    total += 2;
    if (k >= 1500) $display("FAIL areset_reach got state %0d want 3", st);
    else pass_cnt++;
    if (esc !== 18'd24000) $display("FAIL areset_pre got %0d want 24000", esc);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total += 5;
    if (esc !== 18'd12000) $display("FAIL areset_esc got %0d want 12000", esc);
    else pass_cnt++;
    if (s1 !== 18'd12000) $display("FAIL areset_s1 got %0d want 12000", s1);
    else pass_cnt++;
    if (s2 !== 18'd24000) $display("FAIL areset_s2 got %0d want 24000", s2);
    else pass_cnt++;
    if (st !== 3'd0) $display("FAIL areset_state got %0d want 0", st);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    total += 2;
    if (nbusy !== 0) $display("FAIL areset_after_busy got %0d want 0", nbusy);
    else pass_cnt++;
    if (st !== 3'd0) $display("FAIL areset_after_state got %0d want 0", st);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_bounce();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
